// File: rtl/mutex_monitor.sv
// mutex_monitor
// Parametrised N-channel mutual-exclusion monitor for simulation and formal
// benches. Every clock it samples a signal group and flags cycles where more
// than one bit is active (MODE 0) or where the active count is not exactly
// one (MODE 1). A persistence filter requires FILTER consecutive bad cycles
// before a violation is reported, and each contiguous bad run reports once.
// Reported violations pulse viol, bump a saturating counter, set a sticky
// flag and (first time only) capture the offending vector and timestamp.
//
// Optional build macro:
//   MUTEX_MON_ASSERT_EN - when defined, an immediate assertion in the clocked
//                         process raises $error on every reported violation.
//                         Register behaviour is identical either way.
//
// Ports:
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous active-high reset
//   en          in   1      monitor enable
//   clr         in   1      clear counter, sticky flag, capture and filter
//   sig         in   N      monitored signal group
//   viol        out  1      single-cycle violation pulse
//   err_sticky  out  1      set on first reported violation
//   viol_cnt    out  CNT_W  reported violations, saturating
//   first_valid out  1      first-violation capture is valid
//   first_vec   out  N      sig at the first reported violation
//   first_time  out  TS_W   timestamp at the first reported violation
module mutex_monitor #(
    parameter int unsigned N      = 2,
    parameter int unsigned MODE   = 0,
    parameter int unsigned FILTER = 1,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned TS_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [N-1:0]     sig,
    output logic             viol,
    output logic             err_sticky,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             first_valid,
    output logic [N-1:0]     first_vec,
    output logic [TS_W-1:0]  first_time
);

    localparam int unsigned PC_W  = $clog2(N + 1);
    localparam int unsigned RUN_W = (FILTER < 1) ? 1 : $clog2(FILTER + 1);

    logic [TS_W-1:0]  ts;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt_c;
    logic [PC_W-1:0]  pop_c;
    logic             bad_c;
    logic             report_c;

    // Number of active bits in the monitored group.
    function automatic logic [PC_W-1:0] popcount(input logic [N-1:0] v);
        logic [PC_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(N); i++) begin
            acc = acc + PC_W'(v[i]);
        end
        return acc;
    endfunction

    // Bad-cycle detection and filter bookkeeping.
    always_comb begin
        pop_c     = popcount(sig);
        bad_c     = 1'b0;
        run_nxt_c = '0;
        if (MODE == 0) begin
            bad_c = (pop_c > PC_W'(1));
        end else begin
            bad_c = (pop_c != PC_W'(1));
        end
        // Run saturates at FILTER so a long bad run reports only once.
        if (en && bad_c) begin
            run_nxt_c = (run == RUN_W'(FILTER)) ? run : RUN_W'(run + RUN_W'(1));
        end
        report_c = en && bad_c && (run == RUN_W'(FILTER - 1));
    end

    // Free-running timestamp; only reset affects it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // Filter state, reporting and first-violation capture.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            run         <= '0;
            viol        <= 1'b0;
            err_sticky  <= 1'b0;
            viol_cnt    <= '0;
            first_valid <= 1'b0;
            first_vec   <= '0;
            first_time  <= '0;
        end else begin
            run  <= run_nxt_c;
            viol <= report_c;
            if (report_c) begin
                err_sticky <= 1'b1;
                if (!(&viol_cnt)) begin
                    viol_cnt <= viol_cnt + CNT_W'(1);
                end
                if (!first_valid) begin
                    first_valid <= 1'b1;
                    first_vec   <= sig;
                    first_time  <= ts;
                end
            end
`ifdef MUTEX_MON_ASSERT_EN
            assert (!report_c)
            else $error("mutex violation: sig=%b t=%0d", sig, ts);
`endif
        end
    end

endmodule
